// File: rtl/cpu_pkg.sv
// Shared definitions for the fixed-function divide processor: controller states,
// data-memory map and datapath sizing.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ITER   = 24;

  localparam logic [7:0] ADDR_DVD_HI  = 8'd0;
  localparam logic [7:0] ADDR_DVD_LO  = 8'd1;
  localparam logic [7:0] ADDR_DVS     = 8'd2;
  localparam logic [7:0] ADDR_RES_HI  = 8'd4;
  localparam logic [7:0] ADDR_RES_MID = 8'd5;
  localparam logic [7:0] ADDR_RES_LO  = 8'd6;

  typedef enum logic [3:0] {
    IDLE, ARMED, LD0, LD1, LD2, DIV, ST0, ST1, ST2, DONE
  } state_t;

endpackage

// File: rtl/data_mem.sv
// Single-port byte memory: combinational read, write on the rising clock edge.
module data_mem #(
  parameter  int DATA_W    = 8,
  parameter  int MEM_DEPTH = 256,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] Core [MEM_DEPTH];

  // NOTE: the array has no reset; contents survive a controller reset and the
  // host preloads it directly.
  always_ff @(posedge clk) begin
    if (we) Core[addr] <= wdata;
  end

  assign rdata = Core[addr];

endmodule

// File: rtl/cpu.sv
// Divide processor: loads a 16-bit dividend and 8-bit divisor from data memory,
// runs a 24-step restoring division and stores the 16.8 fixed-point quotient.
module cpu #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  import cpu_pkg::*;

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        dvd_hi, dvd_lo, dvs, rem;
  logic [23:0]       num;
  logic [4:0]        cnt;
  logic [8:0]        part_rem;
  logic              q_bit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  data_mem #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) DM1 (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: each always_comb assigns defaults first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (Start) state_nxt = ARMED;
      ARMED:      if (!Start) state_nxt = LD0;
      LD0:        state_nxt = LD1;
      LD1:        state_nxt = LD2;
      LD2:        state_nxt = DIV;
      DIV:        if (cnt == 5'd0) state_nxt = ST0;
      ST0:        state_nxt = ST1;
      ST1:        state_nxt = ST2;
      ST2:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ADDR_DVD_HI;
    mem_wdata = num[7:0];
    case (state)
      LD1: mem_addr = ADDR_DVD_LO;
      LD2: mem_addr = ADDR_DVS;
      ST0: begin mem_we = 1'b1; mem_addr = ADDR_RES_HI;  mem_wdata = num[23:16]; end
      ST1: begin mem_we = 1'b1; mem_addr = ADDR_RES_MID; mem_wdata = num[15:8];  end
      ST2: begin mem_we = 1'b1; mem_addr = ADDR_RES_LO;  mem_wdata = num[7:0];   end
      default: ;
    endcase
  end

  // Numerator bits shift out of num's top while quotient bits shift in at the
  // bottom, so num holds the quotient once all 24 steps are done. A zero
  // divisor always "fits", which yields all-ones without a special case.
  assign part_rem = {rem, num[23]};
  assign q_bit    = (part_rem >= {1'b0, dvs});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dvd_hi <= '0;
      dvd_lo <= '0;
      dvs    <= '0;
      rem    <= '0;
      num    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        LD0: dvd_hi <= mem_rdata;
        LD1: dvd_lo <= mem_rdata;
        LD2: begin
          dvs <= mem_rdata;
          num <= {dvd_hi, dvd_lo, 8'h00};
          rem <= '0;
          cnt <= 5'(ITER - 1);
        end
        DIV: begin
          rem <= q_bit ? 8'(part_rem - {1'b0, dvs}) : part_rem[7:0];
          num <= {num[22:0], q_bit};
          cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                        Ack <= 1'b0;
    else if ((state == IDLE || state == DONE) && Start) Ack <= 1'b0;
    else if (state == ST2)                            Ack <= 1'b1;
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: table of division runs with a result scoreboard,
// plus hand-written mid-run Start and mid-run reset sequences.
module tb_cpu;
  import cpu_pkg::*;

  logic Clk = 1'b0;
  logic Reset, Start;
  logic Ack;

  cpu #(.DATA_W(8), .MEM_DEPTH(256)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    int          hold;
    bit          poke;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs[7];
  logic [23:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] dvd, input logic [7:0] dvs);
    dut.DM1.Core[ADDR_DVD_HI] <= dvd[15:8];
    dut.DM1.Core[ADDR_DVD_LO] <= dvd[7:0];
    dut.DM1.Core[ADDR_DVS]    <= dvs;
  endtask

  task automatic run(input vec_t v, input int idx);
    int          lat;
    logic [23:0] exp_res, got;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    check($sformatf("v%0d_ack_clear", idx), 32'(Ack), 32'd0);
    preload(v.dvd, v.dvs);
    sb.push_back(v.exp);
    repeat (v.hold - 1) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    lat = -1;
    for (int e = 0; e < 100; e++) begin
      @(posedge Clk); #1;
      if (v.poke && e == 10) Start = 1'b1;
      if (v.poke && e == 11) Start = 1'b0;
      if (Ack) begin lat = e; break; end
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd30);
    got = {dut.DM1.Core[ADDR_RES_HI], dut.DM1.Core[ADDR_RES_MID], dut.DM1.Core[ADDR_RES_LO]};
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d_scoreboard: got empty, expected an entry", idx);
    end else begin
      exp_res = sb.pop_front();
      check($sformatf("v%0d_result", idx), 32'(got), 32'(exp_res));
    end
    check($sformatf("v%0d_byte3", idx), 32'(dut.DM1.Core[3]), 32'hA5);
    check($sformatf("v%0d_byte2", idx), 32'(dut.DM1.Core[ADDR_DVS]), 32'(v.dvs));
    repeat (3) @(posedge Clk); #1;
    check($sformatf("v%0d_ack_held", idx), 32'(Ack), 32'd1);
    check($sformatf("v%0d_stable", idx),
          32'({dut.DM1.Core[ADDR_RES_HI], dut.DM1.Core[ADDR_RES_MID], dut.DM1.Core[ADDR_RES_LO]}),
          32'(got));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r_dvd;
    logic [7:0]  r_dvs;

    vecs[0] = '{dvd: 16'd12800,  dvs: 8'd25,  hold: 2, poke: 1'b0, exp: 24'h020000};
    vecs[1] = '{dvd: 16'd385,    dvs: 8'd6,   hold: 1, poke: 1'b0, exp: 24'h00402A};
    vecs[2] = '{dvd: 16'h1234,   dvs: 8'd0,   hold: 3, poke: 1'b0, exp: 24'hFFFFFF};
    vecs[3] = '{dvd: 16'hFFFF,   dvs: 8'd1,   hold: 1, poke: 1'b1, exp: 24'hFFFF00};
    vecs[4] = '{dvd: 16'h0001,   dvs: 8'd255, hold: 2, poke: 1'b0, exp: 24'h000001};
    for (int i = 5; i < 7; i++) begin
      r_dvd   = 16'($urandom);
      r_dvs   = 8'($urandom_range(1, 255));
      vecs[i] = '{dvd: r_dvd, dvs: r_dvs, hold: 1, poke: 1'b0,
                  exp: 24'({r_dvd, 8'h00} / {16'h0000, r_dvs})};
    end

    Reset = 1'b1;
    Start = 1'b0;
    dut.DM1.Core[3] <= 8'hA5;
    #1;
    check("reset_ack", 32'(Ack), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) run(vecs[i], i);

    // Abort a run in the middle of the divide and confirm a clean restart.
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk); #1;
    preload(16'h0C35, 8'h0B);
    @(negedge Clk);
    Start = 1'b0;
    repeat (11) @(posedge Clk);
    #1;
    check("abort_in_div", 32'(dut.state), 32'(DIV));
    #2;
    Reset = 1'b1;
    #1;
    check("abort_ack", 32'(Ack), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_byte2", 32'(dut.DM1.Core[ADDR_DVS]), 32'h0B);
    @(negedge Clk);
    Reset = 1'b0;
    run('{dvd: 16'h0C35, dvs: 8'h0B, hold: 1, poke: 1'b0, exp: 24'h011C17}, 7);

    for (int i = 5; i < 7; i++) run(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
